// File: rtl/lv_pwm_flt_mgr.sv
// PWM fault manager for a low-voltage gate driver path.
//
// Detects rising edges on the mismatch and dead-time error inputs. Each edge:
//   - sets a sticky status bit
//   - bumps a saturating event counter
// An enabled edge also forces the gate low and runs the fault FSM:
//   NORMAL -> FAULT (minimum hold) -> WAIT_CLR (software release) -> RECOVER
//   (wait for the PWM command to go low) -> NORMAL
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_lv_pwm_mmerr     mismatch error level; a rising edge is one event
//   i_lv_pwm_dterr     dead-time error pulse
//   i_lv_pwm_raw       raw PWM gate command
//   i_int_en[1:0]      fault/interrupt enable (bit0 mmerr, bit1 dterr)
//   i_int_clr[1:0]     write-1-to-clear for o_int_sts
//   i_flt_rls          software fault release request
//   i_cnt_clr          clears both event counters
//   o_lv_pwm_gate      registered, fault-gated PWM command
//   o_int_sts[1:0]     sticky event status
//   o_int              |(o_int_sts & i_int_en)
//   o_mmerr_cnt        saturating mismatch event count
//   o_dterr_cnt        saturating dead-time event count
//   o_flt_state        0 NORMAL, 1 FAULT, 2 WAIT_CLR, 3 RECOVER
module lv_pwm_flt_mgr #(
  parameter int unsigned FLT_HOLD_NUM = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lv_pwm_mmerr,
  input  logic             i_lv_pwm_dterr,
  input  logic             i_lv_pwm_raw,
  input  logic [1:0]       i_int_en,
  input  logic [1:0]       i_int_clr,
  input  logic             i_flt_rls,
  input  logic             i_cnt_clr,
  output logic             o_lv_pwm_gate,
  output logic [1:0]       o_int_sts,
  output logic             o_int,
  output logic [CNT_W-1:0] o_mmerr_cnt,
  output logic [CNT_W-1:0] o_dterr_cnt,
  output logic [1:0]       o_flt_state
);

  typedef enum logic [1:0] {
    StNormal  = 2'd0,
    StFault   = 2'd1,
    StWaitClr = 2'd2,
    StRecover = 2'd3
  } state_e;

  localparam logic [15:0] HoldLast = 16'(FLT_HOLD_NUM - 1);

  state_e           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic             mmerr_q, dterr_q;
  logic [1:0]       ev;
  logic             en_ev;
  logic [1:0]       sts_q, sts_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic             gate_q, gate_d;

  // Clear wins over the old count but not over a same-cycle event, which still counts as 1.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             evt,
                                                input logic             clr);
    if (clr) begin
      cnt_next = CNT_W'(evt);
    end else if (evt && (cnt != {CNT_W{1'b1}})) begin
      cnt_next = cnt + CNT_W'(1);
    end else begin
      cnt_next = cnt;
    end
  endfunction

  // Rising-edge detection against the registered copies
  assign ev[0] = i_lv_pwm_mmerr & ~mmerr_q;
  assign ev[1] = i_lv_pwm_dterr & ~dterr_q;
  assign en_ev = |(ev & i_int_en);

  // An event overrides a same-cycle clear on its bit
  assign sts_d    = (sts_q & ~i_int_clr) | ev;
  assign mm_cnt_d = cnt_next(mm_cnt_q, ev[0], i_cnt_clr);
  assign dt_cnt_d = cnt_next(dt_cnt_q, ev[1], i_cnt_clr);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StNormal;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic. An enabled event restarts the hold from any state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (en_ev) begin
      state_d = StFault;
      hold_d  = '0;
    end else begin
      case (state_q)
        StNormal: state_d = StNormal;
        StFault: begin
          if (hold_q >= HoldLast) begin
            state_d = StWaitClr;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        // Release only counts while all status is clear; it is not latched.
        StWaitClr: begin
          if (i_flt_rls && (sts_q == 2'b00)) begin
            state_d = StRecover;
          end
        end
        // Return only on a low command so that no partial pulse escapes
        StRecover: begin
          if (!i_lv_pwm_raw) begin
            state_d = StNormal;
          end
        end
        default: state_d = StNormal;
      endcase
    end
  end

  // Output logic. Gate follows raw only from a NORMAL cycle with no enabled event,
  // so the first NORMAL cycle after RECOVER still presents 0.
  always_comb begin
    gate_d = 1'b0;
    if ((state_q == StNormal) && !en_ev) begin
      gate_d = i_lv_pwm_raw;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mmerr_q  <= 1'b0;
      dterr_q  <= 1'b0;
      sts_q    <= 2'b00;
      mm_cnt_q <= '0;
      dt_cnt_q <= '0;
      gate_q   <= 1'b0;
    end else begin
      mmerr_q  <= i_lv_pwm_mmerr;
      dterr_q  <= i_lv_pwm_dterr;
      sts_q    <= sts_d;
      mm_cnt_q <= mm_cnt_d;
      dt_cnt_q <= dt_cnt_d;
      gate_q   <= gate_d;
    end
  end

  assign o_lv_pwm_gate = gate_q;
  assign o_int_sts     = sts_q;
  assign o_int         = |(sts_q & i_int_en);
  assign o_mmerr_cnt   = mm_cnt_q;
  assign o_dterr_cnt   = dt_cnt_q;
  assign o_flt_state   = state_q;

endmodule
